// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register index, FSM states, control bundle.
// Pure declarations; the load-use helper is combinational.
package hazard_ctrl_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } hzstate_t;

   // Bit order is the order the bench and top pack/unpack the stage controls.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic exmem_flush;
      logic memwb_en;
   } ctl_t;

   localparam ctl_t CTL_NONE = '0;

   function automatic logic load_use(input logic memread, input regbits_t wsel,
                                     input regbits_t rs, input regbits_t rt);
      return memread && (wsel != '0) && ((wsel == rs) || (wsel == rt));
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: decode/latch fields and cache strobes in, stage controls out.
// master = datapath side, slave = controller side.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
   import hazard_ctrl_pkg::*;

   logic       ihit;
   logic       dhit;
   regbits_t   ifid_rs;
   regbits_t   ifid_rt;
   logic       idex_memread;
   regbits_t   idex_wsel;
   logic       exmem_dmemreq;
   logic       exmem_pcsrc;
   logic       exmem_halt;

   logic       pc_en;
   logic       ifid_en;
   logic       ifid_flush;
   logic       idex_en;
   logic       idex_flush;
   logic       exmem_en;
   logic       exmem_flush;
   logic       memwb_en;
   logic       halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ihit, dhit, ifid_rs, ifid_rt, idex_memread, idex_wsel,
             exmem_dmemreq, exmem_pcsrc, exmem_halt,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_en, halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, ifid_rs, ifid_rt, idex_memread, idex_wsel,
             exmem_dmemreq, exmem_pcsrc, exmem_halt,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_en, halted, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones, cleared by reset.
// One-cycle update latency; no backpressure.
module hazard_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, PC enable, halt drain; perf counters under HAZARD_PERF_EN.
// Zero-cycle combinational response to hazard inputs; a pending dcache access freezes the whole pipe.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic               CLK,
   input  logic               nRST,
   hazard_ctrl_if.slave       hz
);

   hzstate_t state, state_nxt;
   ctl_t     ctl;
   logic     halted;
   logic     dwait;
   logic     loaduse;

   assign dwait   = hz.exmem_dmemreq && !hz.dhit;
   assign loaduse = load_use(hz.idex_memread, hz.idex_wsel, hz.ifid_rs, hz.ifid_rt);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      ctl       = CTL_NONE;
      halted    = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: state_nxt = RUN;
         RUN: begin
            if (dwait) begin
               ctl = CTL_NONE;
            end else if (hz.exmem_pcsrc) begin
               // Redirect beats load-use: the dependent instruction is squashed anyway.
               ctl = '{pc_en:1'b1, ifid_en:1'b1, ifid_flush:1'b1, idex_en:1'b1, idex_flush:1'b1,
                       exmem_en:1'b1, exmem_flush:1'b1, memwb_en:1'b1};
            end else if (loaduse) begin
               ctl = '{pc_en:1'b0, ifid_en:1'b0, ifid_flush:1'b0, idex_en:1'b1, idex_flush:1'b1,
                       exmem_en:1'b1, exmem_flush:1'b0, memwb_en:1'b1};
            end else if (!hz.ihit) begin
               ctl = '{pc_en:1'b0, ifid_en:1'b1, ifid_flush:1'b1, idex_en:1'b1, idex_flush:1'b0,
                       exmem_en:1'b1, exmem_flush:1'b0, memwb_en:1'b1};
            end else begin
               ctl = '{pc_en:1'b1, ifid_en:1'b1, ifid_flush:1'b0, idex_en:1'b1, idex_flush:1'b0,
                       exmem_en:1'b1, exmem_flush:1'b0, memwb_en:1'b1};
            end
            if (hz.exmem_halt && ctl.memwb_en) state_nxt = HALT;
         end
         HALT: halted = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

   assign hz.pc_en       = ctl.pc_en;
   assign hz.ifid_en     = ctl.ifid_en;
   assign hz.ifid_flush  = ctl.ifid_flush;
   assign hz.idex_en     = ctl.idex_en;
   assign hz.idex_flush  = ctl.idex_flush;
   assign hz.exmem_en    = ctl.exmem_en;
   assign hz.exmem_flush = ctl.exmem_flush;
   assign hz.memwb_en    = ctl.memwb_en;
   assign hz.halted      = halted;

`ifdef HAZARD_PERF_EN
   logic stall_inc, flush_inc;
   assign stall_inc = (state == RUN) && !ctl.pc_en;
   assign flush_inc = (state == RUN) && (ctl.ifid_flush || ctl.idex_flush);

   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK(CLK), .nRST(nRST), .inc(stall_inc), .count(hz.stall_cnt)
   );
   hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .CLK(CLK), .nRST(nRST), .inc(flush_inc), .count(hz.flush_cnt)
   );
`else
   assign hz.stall_cnt = {CNT_W{1'b0}};
   assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, dcache/icache waits, redirect, halt, perf counters.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int CNT_W = 4;
`ifdef HAZARD_PERF_EN
   localparam logic [CNT_W-1:0] SAT_EXP = 4'd15;
`else
   localparam logic [CNT_W-1:0] SAT_EXP = 4'd0;
`endif

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}
   localparam logic [7:0] C_OFF    = 8'b0000_0000;
   localparam logic [7:0] C_NORM   = 8'b1101_0101;
   localparam logic [7:0] C_REDIR  = 8'b1111_1111;
   localparam logic [7:0] C_LDUSE  = 8'b0001_1101;
   localparam logic [7:0] C_IWAIT  = 8'b0111_0101;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 CLK = ~CLK;

   hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
   hazard_ctrl #(.CNT_W(CNT_W)) dut (.CLK(CLK), .nRST(nRST), .hz(hz.slave));

   task automatic drive(input logic ihit, input logic dhit, input logic [4:0] rs, input logic [4:0] rt,
                        input logic memread, input logic [4:0] wsel, input logic dmemreq,
                        input logic pcsrc, input logic halt);
      hz.ihit = ihit;  hz.dhit = dhit;  hz.ifid_rs = rs;  hz.ifid_rt = rt;
      hz.idex_memread = memread;  hz.idex_wsel = wsel;
      hz.exmem_dmemreq = dmemreq;  hz.exmem_pcsrc = pcsrc;  hz.exmem_halt = halt;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic check(input string tag, input logic [7:0] exp_ctl, input logic exp_halt);
      logic [7:0] obs;
      obs = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
             hz.exmem_en, hz.exmem_flush, hz.memwb_en};
      tests++;
      assert (obs === exp_ctl) else begin
         fails++;
         $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp_ctl);
      end
      tests++;
      assert (hz.halted === exp_halt) else begin
         fails++;
         $error("FAIL %s halted observed=%b expected=%b", tag, hz.halted, exp_halt);
      end
   endtask

   task automatic check_cnt(input string tag, input logic [CNT_W-1:0] exp_stall,
                            input logic [CNT_W-1:0] exp_flush);
      tests++;
      assert (hz.stall_cnt === exp_stall) else begin
         fails++;
         $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, hz.stall_cnt, exp_stall);
      end
      tests++;
      assert (hz.flush_cnt === exp_flush) else begin
         fails++;
         $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, hz.flush_cnt, exp_flush);
      end
   endtask

   initial begin
      // T1 reset and IDLE -> RUN
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      check("reset", C_OFF, 0);
      check_cnt("reset_cnt", 4'd0, 4'd0);
      @(posedge CLK);
      #2 nRST = 1'b1;
      #1 check("idle", C_OFF, 0);
      tick();
      check("run_first", C_NORM, 0);

      // T2 load-use
      drive(1, 0, 5'd5, 5'd0, 1, 5'd5, 0, 0, 0);
      check("lduse_rs", C_LDUSE, 0);
      tick();
      drive(1, 0, 5'd5, 5'd0, 0, 5'd0, 0, 0, 0);
      check("lduse_clear", C_NORM, 0);
      drive(1, 0, 5'd1, 5'd9, 1, 5'd9, 0, 0, 0);
      check("lduse_rt", C_LDUSE, 0);
      drive(1, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
      check("lduse_r0", C_NORM, 0);
      drive(0, 0, 5'd7, 5'd0, 1, 5'd7, 0, 0, 0);
      check("lduse_iwait", C_LDUSE, 0);
      drive(1, 0, 5'd7, 5'd0, 1, 5'd7, 0, 1, 0);
      check("redir_over_lduse", C_REDIR, 0);
      tick();

      // T3 dcache wait defers redirect
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dwait_%0d", i), C_OFF, 0);
         tick();
      end
      drive(1, 1, 0, 0, 0, 0, 1, 1, 0);
      check("dhit_redir", C_REDIR, 0);
      tick();

      // T4 icache miss
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("iwait", C_IWAIT, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("iwait_redir", C_REDIR, 0);
      tick();

      // T5 halt deferred by dwait, then sticky
      drive(1, 0, 0, 0, 0, 0, 1, 0, 1);
      check("halt_dwait", C_OFF, 0);
      tick();
      check("halt_dwait_hold", C_OFF, 0);
      drive(1, 1, 0, 0, 0, 0, 1, 0, 1);
      check("halt_dhit", C_NORM, 0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
               5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         check($sformatf("halted_%0d", i), C_OFF, 1);
         tick();
      end
      nRST = 1'b0;
      #1 check("halt_reset", C_OFF, 0);
      check_cnt("halt_reset_cnt", 4'd0, 4'd0);

      // T6 perf counters: 20 icache-miss cycles stall and flush every cycle
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge CLK);
      #2 nRST = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) tick();
      check("perf_iwait", C_IWAIT, 0);
      check_cnt("perf_sat", SAT_EXP, SAT_EXP);

      // async reset mid-stall
      #1 nRST = 1'b0;
      #1 check("async_rst", C_OFF, 0);
      check_cnt("async_rst_cnt", 4'd0, 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
